// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, buffers one fetched word for decode, and applies redirect/halt.
// Define FETCH_RAS_EN to build the return-address stack for call/return.
module imem_fetch_ctrl #(
   parameter int unsigned          ADDR_W    = 5,
   parameter int unsigned          INST_W    = 16,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter int unsigned          RAS_DEPTH = 4,
   parameter logic [INST_W-1:0]    HALT_WORD = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_adr,
   output logic              imem_en,
   input  logic [INST_W-1:0] imem_data,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              redir_valid,
   input  logic              call_valid,
   input  logic              ret_valid,
   input  logic [ADDR_W-1:0] redir_target,
   output logic              halted,
   output logic              ras_err
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
   logic                valid_q, valid_d;

`ifdef FETCH_RAS_EN
   localparam int unsigned SP_W  = $clog2(RAS_DEPTH + 1);
   localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

   logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];
   logic [SP_W-1:0]     sp_q, sp_d;
   logic                err_q, err_d;
   logic                push_en;
   logic [IDX_W-1:0]    push_idx, pop_idx;
   logic [ADDR_W-1:0]   ret_addr;

   assign push_idx = IDX_W'(sp_q);
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
   assign ret_addr = inst_pc_q + ADDR_W'(1);
`else
   logic                unused_ret;
   logic [31:0]         unused_depth;

   assign unused_ret   = ret_valid;
   assign unused_depth = RAS_DEPTH;
`endif

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         valid_q   <= 1'b0;
`ifdef FETCH_RAS_EN
         sp_q      <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
`ifdef FETCH_RAS_EN
         sp_q      <= sp_d;
         err_q     <= err_d;
`endif
      end
   end

`ifdef FETCH_RAS_EN
   // Entries above the stack pointer are never read, so storage needs no reset.
   always_ff @(posedge clk) begin
      if (push_en) begin
         ras_q[push_idx] <= ret_addr;
      end
   end
`endif

   // Next-state: halt on an accepted HALT_WORD outranks every redirect
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = valid_q;
`ifdef FETCH_RAS_EN
      sp_d      = sp_q;
      err_d     = err_q;
      push_en   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (valid_q && inst_ready && (inst_q == HALT_WORD)) begin
               state_d = S_HALT;
               valid_d = 1'b0;
            end
`ifdef FETCH_RAS_EN
            else if (ret_valid) begin
               valid_d = 1'b0;
               if (sp_q == '0) begin
                  pc_d  = RESET_PC;
                  err_d = 1'b1;
               end else begin
                  pc_d = ras_q[pop_idx];
                  sp_d = sp_q - SP_W'(1);
               end
            end
            else if (call_valid) begin
               valid_d = 1'b0;
               pc_d    = redir_target;
               if (sp_q == SP_FULL) begin
                  err_d = 1'b1;
               end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + SP_W'(1);
               end
            end
`else
            else if (call_valid) begin
               valid_d = 1'b0;
               pc_d    = redir_target;
            end
`endif
            else if (redir_valid) begin
               valid_d = 1'b0;
               pc_d    = redir_target;
            end
            else if (!valid_q || inst_ready) begin
               inst_d    = imem_data;
               inst_pc_d = pc_q;
               valid_d   = 1'b1;
               pc_d      = pc_q + ADDR_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   // Outputs
   always_comb begin
      imem_en    = (state_q == S_FETCH);
      halted     = (state_q == S_HALT);
      imem_adr   = pc_q;
      inst_o     = inst_q;
      inst_pc    = inst_pc_q;
      inst_valid = valid_q;
`ifdef FETCH_RAS_EN
      ras_err    = err_q;
`else
      ras_err    = 1'b0;
`endif
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: the reference model predicts the accepted word stream
// from the PC sequence and redirect targets; directed checks cover reset, latency, halt and stack.
module tb_imem_fetch_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned IW = 16;

   logic          clk = 1'b0;
   logic          rst, start, inst_ready, redir_valid, call_valid, ret_valid;
   logic [AW-1:0] redir_target, imem_adr, inst_pc;
   logic [IW-1:0] imem_data, inst_o;
   logic          imem_en, inst_valid, halted, ras_err;
   logic [IW-1:0] mem [32];

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] w;
   } exp_t;

   exp_t          exp_q [$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic          mon_en = 1'b0;

   always #5 clk = ~clk;

   always_comb imem_data = imem_en ? mem[imem_adr] : '0;

   imem_fetch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .imem_adr     (imem_adr),
      .imem_en      (imem_en),
      .imem_data    (imem_data),
      .inst_o       (inst_o),
      .inst_pc      (inst_pc),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .redir_valid  (redir_valid),
      .call_valid   (call_valid),
      .ret_valid    (ret_valid),
      .redir_target (redir_target),
      .halted       (halted),
      .ras_err      (ras_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", 32'(inst_o), 32'd0);
      chk("rst_pc", 32'(inst_pc), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_err", 32'(ras_err), 32'd0);
      chk("rst_en", 32'(imem_en), 32'd0);
      chk("rst_adr", 32'(imem_adr), 32'd0);
   endtask

   task automatic do_reset();
      start = 1'b0; inst_ready = 1'b0; redir_valid = 1'b0;
      call_valid = 1'b0; ret_valid = 1'b0; redir_target = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   logic [AW-1:0] np, pend_tgt;
   logic          redir_pend;
   int            r, t;
   exp_t          e;

   initial begin
      for (int i = 0; i < 32; i++) begin
         do mem[i] = IW'($urandom); while (mem[i] == 16'hFFFF);
      end

      fork
         forever begin
            @(negedge clk);
            if (mon_en && inst_valid && inst_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL sb_unexpected: inst_pc %0d accepted with nothing expected", inst_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_pc", 32'(inst_pc), 32'(e.pc));
                  chk("sb_word", 32'(inst_o), 32'(e.w));
               end
            end
         end
      join_none

      do_reset();

      // First word appears one edge after the start edge
      pulse_start();
      chk("lat_en", 32'(imem_en), 32'd1);
      chk("lat_valid0", 32'(inst_valid), 32'd0);
      step();
      chk("lat_valid1", 32'(inst_valid), 32'd1);
      chk("lat_pc", 32'(inst_pc), 32'd0);
      chk("lat_word", 32'(inst_o), 32'(mem[0]));
      chk("lat_adr", 32'(imem_adr), 32'd1);

      // Random stream: model tracks the next PC expected to be accepted
      np = '0;
      redir_pend = 1'b0;
      mon_en = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (redir_pend) begin
            chk("flush", 32'(inst_valid), 32'd0);
            exp_q.delete();
            np = pend_tgt;
            redir_pend = 1'b0;
         end
         if (exp_q.size() == 0) begin
            exp_q.push_back({np, mem[np]});
            np = np + AW'(1);
         end
         r = int'($urandom_range(0, 99));
         inst_ready   = ($urandom_range(0, 3) != 0);
         redir_target = AW'($urandom);
         redir_valid  = (r < 8);
`ifdef FETCH_RAS_EN
         call_valid   = 1'b0;
         ret_valid    = 1'b0;
`else
         call_valid   = (r >= 8 && r < 12);
         ret_valid    = (r >= 12 && r < 20) || (r < 2);
`endif
         if (redir_valid || call_valid) begin
            redir_pend = 1'b1;
            pend_tgt   = redir_target;
         end
         step();
      end
      mon_en = 1'b0;
      inst_ready = 1'b0; redir_valid = 1'b0; call_valid = 1'b0; ret_valid = 1'b0;
      exp_q.delete();

      // Halt on accepted HALT_WORD at address 2
      do_reset();
      mem[2] = 16'hFFFF;
      inst_ready = 1'b1;
      pulse_start();
      t = 0;
      while (!halted && t < 20) begin
         step();
         t++;
      end
      chk("halt_reached", 32'(halted), 32'd1);
      chk("halt_en", 32'(imem_en), 32'd0);
      chk("halt_valid", 32'(inst_valid), 32'd0);
      chk("halt_adr", 32'(imem_adr), 32'd3);
      pulse_start();
      repeat (3) step();
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_nostart", 32'(inst_valid), 32'd0);
      chk("halt_en2", 32'(imem_en), 32'd0);
      mem[2] = 16'h1234;

`ifdef FETCH_RAS_EN
      // Call from 1 to 10, return from 11 resumes at 2
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      t = 0;
      while (!(inst_valid && inst_pc == 5'd1) && t < 10) begin step(); t++; end
      chk("ras_at1", 32'(inst_pc), 32'd1);
      call_valid = 1'b1; redir_target = 5'd10;
      step();
      call_valid = 1'b0;
      t = 0;
      while (!(inst_valid && inst_pc == 5'd11) && t < 10) begin step(); t++; end
      chk("ras_at11", 32'(inst_pc), 32'd11);
      ret_valid = 1'b1;
      step();
      ret_valid = 1'b0;
      t = 0;
      while (!inst_valid && t < 5) begin step(); t++; end
      chk("ras_ret_pc", 32'(inst_pc), 32'd2);
      chk("ras_err_clean", 32'(ras_err), 32'd0);
      for (int k = 0; k < 5; k++) begin
         call_valid = 1'b1; redir_target = 5'd20;
         step();
      end
      call_valid = 1'b0;
      chk("ras_overflow", 32'(ras_err), 32'd1);

      // Return with an empty stack goes to RESET_PC
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      t = 0;
      while (!(inst_valid && inst_pc == 5'd3) && t < 10) begin step(); t++; end
      ret_valid = 1'b1;
      step();
      ret_valid = 1'b0;
      t = 0;
      while (!inst_valid && t < 5) begin step(); t++; end
      chk("ras_empty_pc", 32'(inst_pc), 32'd0);
      chk("ras_underflow", 32'(ras_err), 32'd1);
`endif

      // Reset in the middle of a stream
      do_reset();
      inst_ready = 1'b1;
      pulse_start();
      repeat (5) step();
      chk("mid_valid", 32'(inst_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      inst_ready = 1'b0;
      check_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
